alu_arbiter: RTL and testbench

- Shares one combinational 16-bit ALU between NUM_REQ independent requesters.
- Each requester presents an operation with a valid/ready handshake.
- The block grants requesters in round-robin order, drives the ALU operand/control ports from registers, waits ALU_LATENCY cycles, captures the result, and returns it on a single response channel tagged with the requester id.
- Sits between the execution-unit clients and the ALU instance.

---
 rtl/alu_arbiter.sv | 219 +++++++++++++++++++++
 tb/tb_alu_arbiter.sv | 338 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
// -----------------------------------------------------------------------------
// alu_arbiter
//   Shares one combinational 16-bit ALU between NUM_REQ requesters. Requests
//   are granted round-robin. The granted operation is registered onto the ALU
//   input pins and held there for ALU_LATENCY cycles. The ALU result is then
//   captured and returned on a single valid/ready response channel, tagged
//   with the id of the requester that issued it.
//
// Ports
//   clk, rst_n            rising-edge clock, asynchronous active-low reset
//   req_valid/req_ready   per-requester handshake (at most one ready bit high)
//   req_a/req_b           16-bit operands, requester i at [16i+15:16i]
//   req_select            4-bit ALU select code per requester
//   req_mode              ALU mode per requester (0 arithmetic, 1 logic)
//   req_carry_in          ALU carry input per requester
//   alu_in_a/alu_in_b     registered operands driven to the ALU
//   alu_select/alu_mode/alu_carry_in  registered control driven to the ALU
//   alu_out/alu_carry_out/alu_compare  ALU results, sampled after the latency
//   rsp_valid/rsp_ready   response handshake
//   rsp_id                index of the requester that owns the response
//   rsp_data/rsp_carry/rsp_compare  captured ALU results
//   busy                  high whenever the block is not idle
// -----------------------------------------------------------------------------
module alu_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int ALU_LATENCY = 1,
  parameter int ID_W        = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NUM_REQ-1:0]     req_valid,
  output logic [NUM_REQ-1:0]     req_ready,
  input  logic [16*NUM_REQ-1:0]  req_a,
  input  logic [16*NUM_REQ-1:0]  req_b,
  input  logic [4*NUM_REQ-1:0]   req_select,
  input  logic [NUM_REQ-1:0]     req_mode,
  input  logic [NUM_REQ-1:0]     req_carry_in,
  output logic [15:0]            alu_in_a,
  output logic [15:0]            alu_in_b,
  output logic [3:0]             alu_select,
  output logic                   alu_mode,
  output logic                   alu_carry_in,
  input  logic [15:0]            alu_out,
  input  logic                   alu_carry_out,
  input  logic                   alu_compare,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [ID_W-1:0]        rsp_id,
  output logic [15:0]            rsp_data,
  output logic                   rsp_carry,
  output logic                   rsp_compare,
  output logic                   busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  // Counter reload value; EXEC lasts ALU_LATENCY cycles.
  localparam logic [3:0]      WAIT_INIT = 4'(ALU_LATENCY - 1);
  // Pointer starts at the last requester so requester 0 wins first.
  localparam logic [ID_W-1:0] LAST_INIT = ID_W'(NUM_REQ - 1);

  // Per-requester views of the packed request buses.
  logic [15:0] a_arr   [NUM_REQ];
  logic [15:0] b_arr   [NUM_REQ];
  logic [3:0]  sel_arr [NUM_REQ];

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
    assign a_arr[gi]   = req_a[16*gi +: 16];
    assign b_arr[gi]   = req_b[16*gi +: 16];
    assign sel_arr[gi] = req_select[4*gi +: 4];
  end

  state_t          state_q, state_d;
  logic [ID_W-1:0] last_grant_q, last_grant_d;
  logic [3:0]      wait_q, wait_d;
  logic [ID_W-1:0] id_q, id_d;
  logic [15:0]     alu_a_q, alu_a_d;
  logic [15:0]     alu_b_q, alu_b_d;
  logic [3:0]      alu_sel_q, alu_sel_d;
  logic            alu_mode_q, alu_mode_d;
  logic            alu_cin_q, alu_cin_d;
  logic            rsp_valid_q, rsp_valid_d;
  logic [ID_W-1:0] rsp_id_q, rsp_id_d;
  logic [15:0]     rsp_data_q, rsp_data_d;
  logic            rsp_carry_q, rsp_carry_d;
  logic            rsp_cmp_q, rsp_cmp_d;

  // Round-robin search: first valid requester starting just after the
  // previous grant, wrapping modulo NUM_REQ.
  logic [ID_W-1:0] winner;
  logic            found;
  int              cand;

  always_comb begin
    winner = '0;
    found  = 1'b0;
    cand   = 0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = (int'(last_grant_q) + k) % NUM_REQ;
      if (!found && req_valid[ID_W'(cand)]) begin
        found  = 1'b1;
        winner = ID_W'(cand);
      end
    end
  end

  // Ready is only offered in IDLE, so the winner's valid implies acceptance.
  always_comb begin
    req_ready = '0;
    if (state_q == IDLE && found) begin
      req_ready[winner] = 1'b1;
    end
  end

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    wait_d       = wait_q;
    id_d         = id_q;
    alu_a_d      = alu_a_q;
    alu_b_d      = alu_b_q;
    alu_sel_d    = alu_sel_q;
    alu_mode_d   = alu_mode_q;
    alu_cin_d    = alu_cin_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_id_d     = rsp_id_q;
    rsp_data_d   = rsp_data_q;
    rsp_carry_d  = rsp_carry_q;
    rsp_cmp_d    = rsp_cmp_q;
    case (state_q)
      IDLE: begin
        if (found) begin
          alu_a_d      = a_arr[winner];
          alu_b_d      = b_arr[winner];
          alu_sel_d    = sel_arr[winner];
          alu_mode_d   = req_mode[winner];
          alu_cin_d    = req_carry_in[winner];
          id_d         = winner;
          last_grant_d = winner;
          wait_d       = WAIT_INIT;
          state_d      = EXEC;
        end
      end
      EXEC: begin
        if (wait_q == 4'd0) begin
          rsp_data_d  = alu_out;
          rsp_carry_d = alu_carry_out;
          rsp_cmp_d   = alu_compare;
          rsp_id_d    = id_q;
          rsp_valid_d = 1'b1;
          state_d     = RESP;
        end else begin
          wait_d = wait_q - 4'd1;
        end
      end
      RESP: begin
        // Only rsp_ready sampled while in RESP releases the response.
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      last_grant_q <= LAST_INIT;
      wait_q       <= '0;
      id_q         <= '0;
      alu_a_q      <= '0;
      alu_b_q      <= '0;
      alu_sel_q    <= '0;
      alu_mode_q   <= 1'b0;
      alu_cin_q    <= 1'b0;
      rsp_valid_q  <= 1'b0;
      rsp_id_q     <= '0;
      rsp_data_q   <= '0;
      rsp_carry_q  <= 1'b0;
      rsp_cmp_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      wait_q       <= wait_d;
      id_q         <= id_d;
      alu_a_q      <= alu_a_d;
      alu_b_q      <= alu_b_d;
      alu_sel_q    <= alu_sel_d;
      alu_mode_q   <= alu_mode_d;
      alu_cin_q    <= alu_cin_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_id_q     <= rsp_id_d;
      rsp_data_q   <= rsp_data_d;
      rsp_carry_q  <= rsp_carry_d;
      rsp_cmp_q    <= rsp_cmp_d;
    end
  end

  assign alu_in_a     = alu_a_q;
  assign alu_in_b     = alu_b_q;
  assign alu_select   = alu_sel_q;
  assign alu_mode     = alu_mode_q;
  assign alu_carry_in = alu_cin_q;
  assign rsp_valid    = rsp_valid_q;
  assign rsp_id       = rsp_id_q;
  assign rsp_data     = rsp_data_q;
  assign rsp_carry    = rsp_carry_q;
  assign rsp_compare  = rsp_cmp_q;
  assign busy         = (state_q != IDLE);

endmodule

// File: tb/tb_alu_arbiter.sv
// -----------------------------------------------------------------------------
// tb_alu_arbiter
//   Drives alu_arbiter (ALU_LATENCY=1 and a second instance with
//   ALU_LATENCY=3) with directed and random requests. A small ALU stub answers
//   on the alu_* pins. Grants, latency and responses are predicted from a
//   round-robin pointer model and the same ALU function applied to the
//   requested operands.
// -----------------------------------------------------------------------------
module tb_alu_arbiter;

  localparam int N    = 4;
  localparam int LAT  = 1;
  localparam int LAT3 = 3;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [N-1:0]    req_valid;
  logic [N-1:0]    req_ready;
  logic [16*N-1:0] req_a;
  logic [16*N-1:0] req_b;
  logic [4*N-1:0]  req_select;
  logic [N-1:0]    req_mode;
  logic [N-1:0]    req_carry_in;
  logic [15:0]     alu_in_a, alu_in_b, alu_out;
  logic [3:0]      alu_select;
  logic            alu_mode, alu_carry_in, alu_carry_out, alu_compare;
  logic            rsp_valid, rsp_ready, rsp_carry, rsp_compare, busy;
  logic [1:0]      rsp_id;
  logic [15:0]     rsp_data;

  // Second instance, latency 3; shares the operand buses.
  logic [N-1:0]    req_valid3, req_ready3;
  logic [15:0]     alu_in_a3, alu_in_b3, alu_out3;
  logic [3:0]      alu_select3;
  logic            alu_mode3, alu_carry_in3, alu_carry_out3, alu_compare3;
  logic            rsp_valid3, rsp_ready3, rsp_carry3, rsp_compare3, busy3;
  logic [1:0]      rsp_id3;
  logic [15:0]     rsp_data3;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int last_grant_m;
  int last_acc;
  logic [15:0] last_rsp;
  logic [3:0]  sels [5] = '{4'h6, 4'h9, 4'hB, 4'hE, 4'h0};

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural ALU: returns {compare, carry_out, result}.
  function automatic logic [17:0] alu_fn(input logic [15:0] a, input logic [15:0] b,
                                         input logic [3:0] s, input logic m, input logic c);
    logic [16:0] sum;
    logic [15:0] f;
    logic        co;
    sum = '0;
    if (m) begin
      case (s)
        4'b0110: f = a ^ b;
        4'b1011: f = a & b;
        4'b1110: f = a | b;
        default: f = ~a;
      endcase
      co = 1'b0;
    end else begin
      case (s)
        4'b1001: sum = {1'b0, a} + {1'b0, b} + {16'd0, c};
        4'b0110: sum = {1'b0, a} + {1'b0, ~b} + {16'd0, c};
        default: sum = {1'b0, a} + {16'd0, c};
      endcase
      f  = sum[15:0];
      co = sum[16];
    end
    return {(a == b), co, f};
  endfunction

  always_comb {alu_compare, alu_carry_out, alu_out} =
      alu_fn(alu_in_a, alu_in_b, alu_select, alu_mode, alu_carry_in);
  always_comb {alu_compare3, alu_carry_out3, alu_out3} =
      alu_fn(alu_in_a3, alu_in_b3, alu_select3, alu_mode3, alu_carry_in3);

  alu_arbiter #(.NUM_REQ(N), .ALU_LATENCY(LAT), .ID_W(2)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_select(req_select),
    .req_mode(req_mode), .req_carry_in(req_carry_in),
    .alu_in_a(alu_in_a), .alu_in_b(alu_in_b), .alu_select(alu_select),
    .alu_mode(alu_mode), .alu_carry_in(alu_carry_in),
    .alu_out(alu_out), .alu_carry_out(alu_carry_out), .alu_compare(alu_compare),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_data(rsp_data), .rsp_carry(rsp_carry), .rsp_compare(rsp_compare),
    .busy(busy)
  );

  alu_arbiter #(.NUM_REQ(N), .ALU_LATENCY(LAT3), .ID_W(2)) u_dut3 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid3), .req_ready(req_ready3),
    .req_a(req_a), .req_b(req_b), .req_select(req_select),
    .req_mode(req_mode), .req_carry_in(req_carry_in),
    .alu_in_a(alu_in_a3), .alu_in_b(alu_in_b3), .alu_select(alu_select3),
    .alu_mode(alu_mode3), .alu_carry_in(alu_carry_in3),
    .alu_out(alu_out3), .alu_carry_out(alu_carry_out3), .alu_compare(alu_compare3),
    .rsp_valid(rsp_valid3), .rsp_ready(rsp_ready3), .rsp_id(rsp_id3),
    .rsp_data(rsp_data3), .rsp_carry(rsp_carry3), .rsp_compare(rsp_compare3),
    .busy(busy3)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Round-robin rule: the valid requester closest after the last grant.
  function automatic int rr_pick(input logic [N-1:0] v);
    int best  = -1;
    int bestd = N;
    for (int i = 0; i < N; i++) begin
      if (v[i]) begin
        int d = (i - last_grant_m - 1 + 2*N) % N;
        if (d < bestd) begin
          bestd = d;
          best  = i;
        end
      end
    end
    return best;
  endfunction

  task automatic set_op(input int i, input logic [15:0] a, input logic [15:0] b,
                        input logic [3:0] s, input logic m, input logic c);
    req_a[16*i +: 16]     = a;
    req_b[16*i +: 16]     = b;
    req_select[4*i +: 4]  = s;
    req_mode[i]           = m;
    req_carry_in[i]       = c;
  endtask

  task automatic rand_op(input int i);
    set_op(i, 16'($urandom), 16'($urandom), sels[$urandom_range(0, 4)],
           1'($urandom), 1'($urandom));
    req_valid[i] = 1'b1;
  endtask

  // One arbitration/response transaction on the latency-1 instance.
  // Entered at a negedge with the block idle and requests already driven.
  task automatic run_one(input int stall, input bit reload);
    int          w;
    int          lat;
    logic [N-1:0] exp_rdy;
    logic [37:0] eop;
    logic [17:0] er;
    w = rr_pick(req_valid);
    exp_rdy = '0;
    if (w >= 0) exp_rdy[w] = 1'b1;
    #1 chk("req_ready", req_ready, exp_rdy);
    if (w < 0) begin
      @(posedge clk);
      @(negedge clk);
      chk("idle_stays", busy, 0);
      return;
    end
    eop = {req_carry_in[w], req_mode[w], req_select[4*w +: 4], req_b[16*w +: 16], req_a[16*w +: 16]};
    er  = alu_fn(eop[15:0], eop[31:16], eop[35:32], eop[36], eop[37]);
    @(posedge clk);
    last_acc     = cyc;
    last_grant_m = w;
    @(negedge clk);
    if (reload) rand_op(w);
    else req_valid[w] = 1'b0;
    chk("busy_exec", busy, 1);
    lat = 0;
    while (rsp_valid !== 1'b1 && lat < 40) begin
      chk("alu_pins", {alu_carry_in, alu_mode, alu_select, alu_in_b, alu_in_a}, eop);
      chk("exec_ready", req_ready, 0);
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    chk("latency", lat, LAT);
    chk("rsp_id", rsp_id, w);
    chk("rsp_fields", {rsp_compare, rsp_carry, rsp_data}, er);
    last_rsp  = rsp_data;
    rsp_ready = (stall == 0);
    for (int s = 0; s < stall; s++) begin
      @(posedge clk);
      @(negedge clk);
      chk("stall_valid", rsp_valid, 1);
      chk("stall_fields", {rsp_id, rsp_compare, rsp_carry, rsp_data}, {2'(w), er});
      #1 chk("stall_ready", req_ready, 0);
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("rsp_drop", rsp_valid, 0);
    chk("back_idle", busy, 0);
  endtask

  initial begin
    int lat;
    int prev;
    int dropped;
    int cnt;
    rst_n        = 1'b0;
    req_valid    = '0;
    req_valid3   = '0;
    req_a        = '0;
    req_b        = '0;
    req_select   = '0;
    req_mode     = '0;
    req_carry_in = '0;
    rsp_ready    = 1'b1;
    rsp_ready3   = 1'b1;
    last_grant_m = N - 1;
    last_acc     = 0;
    last_rsp     = '0;

    // Reset state
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_rsp", {rsp_valid, rsp_id, rsp_data, rsp_carry, rsp_compare}, 0);
    chk("rst_alu", {alu_carry_in, alu_mode, alu_select, alu_in_b, alu_in_a}, 0);
    chk("rst_ready", req_ready, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Single op: XOR from requester 2
    set_op(2, 16'hF0F0, 16'hFF00, 4'b0110, 1'b1, 1'b0);
    req_valid[2] = 1'b1;
    run_one(0, 0);
    chk("xor_const", last_rsp, 16'h0FF0);

    // Backpressure: ADD from requester 1, 5 stalled cycles
    set_op(1, 16'h1234, 16'h0001, 4'b1001, 1'b0, 1'b0);
    req_valid[1] = 1'b1;
    set_op(3, 16'h5555, 16'h0F0F, 4'b1110, 1'b1, 1'b0);
    run_one(5, 0);
    chk("add_const", last_rsp, 16'h1235);

    // Reset mid-EXEC after granting requester 1
    set_op(1, 16'hAAAA, 16'h5555, 4'b1011, 1'b1, 1'b0);
    req_valid = 4'b0010;
    #1 chk("pre_rst_ready", req_ready, 4'b0010);
    @(posedge clk);
    @(negedge clk);
    req_valid = '0;
    chk("pre_rst_busy", busy, 1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", rsp_valid, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_alu", {alu_carry_in, alu_mode, alu_select, alu_in_b, alu_in_a}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    last_grant_m = N - 1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("no_stale_rsp", rsp_valid, 0);
    end
    rand_op(0);
    rand_op(2);
    run_one(0, 0);
    chk("post_rst_first", last_grant_m, 0);
    req_valid = '0;

    // Round-robin: everyone valid continuously
    for (int i = 0; i < N; i++) rand_op(i);
    prev = -1;
    for (int k = 0; k < 2*N; k++) begin
      run_one(0, 1);
      if (k > 0) chk("issue_interval", last_acc - prev, LAT + 2);
      prev = last_acc;
    end
    req_valid = '0;

    // Fairness under drop
    rand_op(0);
    rand_op(1);
    rand_op(2);
    run_one(0, 0);
    dropped = rr_pick(req_valid);
    req_valid[dropped] = 1'b0;
    run_one(0, 0);
    rand_op(dropped);
    rand_op(3);
    cnt = 0;
    while (req_valid[dropped] && cnt < N) begin
      run_one(0, 0);
      cnt++;
    end
    chk("fair_served", req_valid[dropped], 0);
    req_valid = '0;

    // Random traffic
    for (int k = 0; k < 40; k++) begin
      for (int i = 0; i < N; i++) begin
        if (!req_valid[i] && ($urandom_range(0, 2) == 0)) rand_op(i);
      end
      run_one($urandom_range(0, 2), 0);
    end
    req_valid = '0;

    // Latency-3 instance
    @(negedge clk);
    set_op(0, 16'h00FF, 16'h0F0F, 4'b1001, 1'b0, 1'b1);
    req_valid3 = 4'b0001;
    #1 chk("l3_ready", req_ready3, 4'b0001);
    @(posedge clk);
    @(negedge clk);
    req_valid3 = '0;
    lat = 0;
    while (rsp_valid3 !== 1'b1 && lat < 40) begin
      chk("l3_alu_pins", {alu_carry_in3, alu_mode3, alu_select3, alu_in_b3, alu_in_a3},
          {1'b1, 1'b0, 4'b1001, 16'h0F0F, 16'h00FF});
      chk("l3_busy", busy3, 1);
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    chk("l3_latency", lat, LAT3);
    chk("l3_rsp_id", rsp_id3, 0);
    chk("l3_fields", {rsp_compare3, rsp_carry3, rsp_data3},
        alu_fn(16'h00FF, 16'h0F0F, 4'b1001, 1'b0, 1'b1));
    chk("l3_const", rsp_data3, 16'h100F);
    @(posedge clk);
    @(negedge clk);
    chk("l3_drop", {rsp_valid3, busy3}, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
